// File: rtl/snn_pkg.sv
// Shared constants and state encoding for the neuron potential sequencer.
// Values are IEEE-754 single precision bit patterns.
package snn_pkg;

  localparam logic [31:0] FP32_ZERO         = 32'h0000_0000;
  localparam int          FP_EXP_MSB        = 30;
  localparam int          FP_EXP_LSB        = 23;
  localparam logic [31:0] DEFAULT_THRESHOLD = 32'h4287c7ae;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_COLLECT,
    ST_DECAY,
    ST_ISSUE,
    ST_CAPTURE,
    ST_EMIT,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/neuron_potential_sequencer_weight_fifo.sv
// Synchronous weight buffer; next_head exposes the entry behind the head so
// the sequencer can load the following operand on the same edge it pops.
module weight_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [W-1:0]               next_head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign rd_next   = rd_ptr + PTR_ONE;
  assign head      = mem[rd_ptr];
  assign next_head = mem[rd_next];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/neuron_potential_sequencer.sv
// Per-neuron timestep controller: buffers weights, decays the membrane
// potential, runs one adder transaction per weight and forwards a spike.
//
// state   | meaning
// INIT    | post-reset: release adder clear, pulse adder set
// IDLE    | waiting for timestep_start
// COLLECT | accepting weights into the FIFO until timestep_end
// DECAY   | potential >> DECAY_SHIFT in the exponent, latch run value
// ISSUE   | adder operands held stable for ADDER_LAT cycles
// CAPTURE | sample adder result, pop FIFO, loop or commit
// EMIT    | spike_valid held until spike_ready
// DONE    | one-cycle done pulse
module neuron_potential_sequencer
  import snn_pkg::*;
#(
  parameter int                FIFO_DEPTH  = 8,
  parameter int                DECAY_SHIFT = 1,
  parameter int                ADDER_LAT   = 1,
  parameter int                ID_W        = 8,
  parameter logic [ID_W-1:0]   NEURON_ID   = '0
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            timestep_start,
  input  logic            timestep_end,
  input  logic            weight_valid,
  input  logic [31:0]     weight_in,
  output logic            weight_ready,
  output logic [31:0]     adder_input_weight,
  output logic [31:0]     adder_decayed_potential,
  output logic            adder_clear,
  output logic            adder_set,
  input  logic [31:0]     adder_final_potential,
  input  logic            adder_spike,
  output logic            spike_valid,
  output logic [ID_W-1:0] spike_id,
  input  logic            spike_ready,
  output logic [31:0]     potential,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = $clog2(ADDER_LAT + 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(ADDER_LAT - 1);
  localparam logic [7:0]    EXP_MAX  = 8'hFF;
  localparam logic [7:0]    SHIFT_E  = 8'(DECAY_SHIFT);

  seq_state_t     state;
  logic [31:0]    run_v;
  logic           spiked;
  logic [LW-1:0]  lat_cnt;
  logic [31:0]    v_dec;
  logic           spiked_next;
  logic [31:0]    fifo_head;
  logic [31:0]    fifo_next;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  // Decay halves by adjusting only the exponent; Inf/NaN pass through and
  // anything that would reach the denormal range flushes to +0.
  function automatic logic [31:0] decay(input logic [31:0] v);
    logic [7:0] e;
    e = v[FP_EXP_MSB:FP_EXP_LSB];
    if (e == EXP_MAX)      return v;
    else if (e <= SHIFT_E) return FP32_ZERO;
    else                   return {v[31], e - SHIFT_E, v[FP_EXP_LSB-1:0]};
  endfunction

  assign v_dec        = decay(potential);
  assign spiked_next  = spiked | adder_spike;
  assign weight_ready = (state == ST_COLLECT) && !fifo_full;
  assign busy         = (state != ST_IDLE);

  weight_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk       (clk),
    .clear     (clear),
    .push      (weight_valid && weight_ready),
    .push_data (weight_in),
    .pop       (state == ST_CAPTURE),
    .head      (fifo_head),
    .next_head (fifo_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state                   <= ST_INIT;
      potential               <= FP32_ZERO;
      run_v                   <= FP32_ZERO;
      spiked                  <= 1'b0;
      lat_cnt                 <= '0;
      adder_input_weight      <= FP32_ZERO;
      adder_decayed_potential <= FP32_ZERO;
      adder_clear             <= 1'b1;
      adder_set               <= 1'b0;
      spike_valid             <= 1'b0;
      spike_id                <= '0;
      done                    <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (!adder_set) begin
            adder_clear <= 1'b0;
            adder_set   <= 1'b1;
          end else begin
            adder_set <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          adder_set <= 1'b0;
          if (timestep_start) state <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (timestep_end) state <= ST_DECAY;
        end
        ST_DECAY: begin
          run_v  <= v_dec;
          spiked <= 1'b0;
          if (fifo_empty) begin
            potential <= v_dec;
            done      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            adder_input_weight      <= fifo_head;
            adder_decayed_potential <= v_dec;
            lat_cnt                 <= LAT_LOAD;
            state                   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (lat_cnt == '0) state <= ST_CAPTURE;
          else               lat_cnt <= lat_cnt - LW'(1);
        end
        ST_CAPTURE: begin
          run_v  <= adder_final_potential;
          spiked <= spiked_next;
          if (fifo_count != CW'(1)) begin
            // The entry behind the head becomes the head on this same edge.
            adder_input_weight      <= fifo_next;
            adder_decayed_potential <= adder_final_potential;
            lat_cnt                 <= LAT_LOAD;
            state                   <= ST_ISSUE;
          end else begin
            potential <= adder_final_potential;
            if (spiked_next) begin
              spike_valid <= 1'b1;
              spike_id    <= NEURON_ID;
              state       <= ST_EMIT;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_EMIT: begin
          if (spike_ready) begin
            spike_valid <= 1'b0;
            spike_id    <= '0;
            done        <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_potential_sequencer.sv
// Directed bench for neuron_potential_sequencer with a behavioural LIF adder
// (real-valued add, threshold compare, fixed reset value on spike).
module tb_neuron_potential_sequencer;
  import snn_pkg::*;

  localparam int              FIFO_DEPTH  = 8;
  localparam int              DECAY_SHIFT = 1;
  localparam int              ADDER_LAT   = 3;
  localparam int              ID_W        = 8;
  localparam logic [ID_W-1:0] NEURON_ID   = 8'h5A;
  localparam logic [31:0]     ADDER_RESET_V = 32'h40D80000;

  logic            clk = 1'b0;
  logic            clear;
  logic            timestep_start, timestep_end;
  logic            weight_valid;
  logic [31:0]     weight_in;
  logic            weight_ready;
  logic [31:0]     adder_input_weight, adder_decayed_potential;
  logic            adder_clear, adder_set;
  logic [31:0]     adder_final_potential;
  logic            adder_spike;
  logic            spike_valid;
  logic [ID_W-1:0] spike_id;
  logic            spike_ready;
  logic [31:0]     potential;
  logic            busy, done;

  int checks   = 0;
  int failures = 0;
  int spike_cycles = 0;

  neuron_potential_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH), .DECAY_SHIFT (DECAY_SHIFT), .ADDER_LAT (ADDER_LAT),
    .ID_W (ID_W), .NEURON_ID (NEURON_ID)
  ) dut (
    .clk (clk), .clear (clear),
    .timestep_start (timestep_start), .timestep_end (timestep_end),
    .weight_valid (weight_valid), .weight_in (weight_in), .weight_ready (weight_ready),
    .adder_input_weight (adder_input_weight), .adder_decayed_potential (adder_decayed_potential),
    .adder_clear (adder_clear), .adder_set (adder_set),
    .adder_final_potential (adder_final_potential), .adder_spike (adder_spike),
    .spike_valid (spike_valid), .spike_id (spike_id), .spike_ready (spike_ready),
    .potential (potential), .busy (busy), .done (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (spike_valid) spike_cycles++;

  function automatic real fp2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'h00) return 0.0;
    d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  always_comb begin
    real sum_r;
    sum_r = fp2r(adder_input_weight) + fp2r(adder_decayed_potential);
    if (adder_input_weight[30:23] == 8'hFF) begin
      adder_final_potential = adder_input_weight;
      adder_spike = 1'b0;
    end else if (sum_r >= fp2r(DEFAULT_THRESHOLD)) begin
      adder_final_potential = ADDER_RESET_V;
      adder_spike = 1'b1;
    end else begin
      adder_final_potential = r2fp(sum_r);
      adder_spike = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    clear = 1'b1;
    #1;
    check("rst_potential", potential, 32'h0);
    check("rst_spike_valid", spike_valid, 1'b0);
    check("rst_adder_clear", adder_clear, 1'b1);
    check("rst_adder_set", adder_set, 1'b0);
    check("rst_weight_ready", weight_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_adder_w", adder_input_weight, 32'h0);
    tick;
    clear = 1'b0;
    tick;
    check("init_adder_set", adder_set, 1'b1);
    check("init_adder_clear", adder_clear, 1'b0);
    check("init_busy", busy, 1'b1);
    tick;
    check("idle_adder_set", adder_set, 1'b0);
    check("idle_busy", busy, 1'b0);
  endtask

  task automatic start_ts;
    timestep_start = 1'b1; tick; timestep_start = 1'b0;
  endtask

  task automatic push_w(input logic [31:0] w);
    weight_valid = 1'b1; weight_in = w; tick; weight_valid = 1'b0;
  endtask

  task automatic end_ts;
    timestep_end = 1'b1; tick; timestep_end = 1'b0;
  endtask

  task automatic finish_ts(output int dcnt, output bit spk, output logic [ID_W-1:0] id);
    dcnt = 0; spk = 1'b0; id = '0;
    for (int i = 0; i < 300; i++) begin
      if (done) dcnt++;
      if (spike_valid) begin spk = 1'b1; id = spike_id; end
      if (!busy) return;
      tick;
    end
    check("finish_timeout_busy", busy, 1'b0);
  endtask

  initial begin
    int dcnt;
    bit spk;
    logic [ID_W-1:0] id;
    logic [31:0] wts [9];
    logic [31:0] seen_w [$];
    int seen_t [$];
    logic [31:0] prev_w;
    bit held;

    wts = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
            32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
    clear = 1'b1; timestep_start = 0; timestep_end = 0; weight_valid = 0;
    weight_in = 32'h0; spike_ready = 1'b1;
    tick; tick;
    do_reset;

    // Stray controls in IDLE are ignored
    weight_valid = 1'b1; weight_in = 32'h3F800000; timestep_end = 1'b1;
    #1;
    check("idle_weight_ready", weight_ready, 1'b0);
    tick;
    weight_valid = 1'b0; timestep_end = 1'b0;
    check("idle_end_ignored_busy", busy, 1'b0);

    // Single weight from zero, weight and end in the same cycle
    start_ts;
    check("collect_weight_ready", weight_ready, 1'b1);
    weight_valid = 1'b1; weight_in = 32'h42470A3D; timestep_end = 1'b1;
    tick;
    weight_valid = 1'b0; timestep_end = 1'b0;
    finish_ts(dcnt, spk, id);
    check("single_potential", potential, 32'h42470A3D);
    check("single_no_spike", spk, 1'b0);
    check("single_done_once", dcnt, 1);

    // Decay then spike
    start_ts;
    push_w(32'h42470A3D);
    end_ts;
    tick;
    check("spk_decayed_operand", adder_decayed_potential, 32'h41C70A3D);
    check("spk_weight_operand", adder_input_weight, 32'h42470A3D);
    finish_ts(dcnt, spk, id);
    check("spk_seen", spk, 1'b1);
    check("spk_id", id, NEURON_ID);
    check("spk_potential", potential, ADDER_RESET_V);
    check("spk_done_once", dcnt, 1);

    // Decay underflow and Inf passthrough
    do_reset;
    start_ts; push_w(32'h00800000); end_ts; finish_ts(dcnt, spk, id);
    check("min_normal_potential", potential, 32'h00800000);
    start_ts; end_ts; finish_ts(dcnt, spk, id);
    check("underflow_potential", potential, 32'h00000000);
    check("empty_done_once", dcnt, 1);
    start_ts; push_w(32'h7F800000); end_ts; finish_ts(dcnt, spk, id);
    check("inf_potential", potential, 32'h7F800000);
    start_ts; end_ts; finish_ts(dcnt, spk, id);
    check("inf_decay_potential", potential, 32'h7F800000);

    // FIFO full and ordering
    do_reset;
    start_ts;
    for (int k = 0; k < 9; k++) begin
      weight_valid = 1'b1; weight_in = wts[k];
      #1;
      check($sformatf("fill_ready_%0d", k), weight_ready, (k < FIFO_DEPTH) ? 1'b1 : 1'b0);
      tick;
    end
    check("full_ready_hold", weight_ready, 1'b0);
    timestep_end = 1'b1; tick; timestep_end = 1'b0; weight_valid = 1'b0;
    prev_w = adder_input_weight;
    for (int c = 0; c < 400 && busy; c++) begin
      tick;
      if (adder_input_weight !== prev_w) begin
        seen_w.push_back(adder_input_weight);
        seen_t.push_back(c);
        prev_w = adder_input_weight;
      end
    end
    check("order_idle", busy, 1'b0);
    check("order_count", seen_w.size(), FIFO_DEPTH);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (i < seen_w.size()) check($sformatf("order_w%0d", i), seen_w[i], wts[i]);
      if (i + 1 < seen_t.size())
        check($sformatf("order_hold%0d", i), seen_t[i+1] - seen_t[i], ADDER_LAT + 1);
    end
    check("order_potential", potential, 32'h42100000);

    // Spike backpressure: 36 decays to 18, plus 60 spikes
    spike_ready = 1'b0;
    start_ts; push_w(32'h42700000); end_ts;
    for (int c = 0; c < 100 && !spike_valid; c++) tick;
    check("bp_spike_valid", spike_valid, 1'b1);
    held = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      if (!spike_valid || done) held = 1'b0;
    end
    check("bp_held", held, 1'b1);
    check("bp_spike_id", spike_id, NEURON_ID);
    check("bp_potential", potential, ADDER_RESET_V);
    spike_ready = 1'b1;
    tick;
    check("bp_accept_valid", spike_valid, 1'b0);
    check("bp_accept_done", done, 1'b1);
    tick;
    check("bp_done_pulse", done, 1'b0);
    check("bp_idle", busy, 1'b0);

    // Clear during ISSUE discards queued weights and the pending spike
    start_ts; push_w(32'h428C0000); push_w(32'h3F800000); end_ts;
    tick;
    check("issue_operand", adder_input_weight, 32'h428C0000);
    spike_cycles = 0;
    do_reset;
    start_ts; end_ts; finish_ts(dcnt, spk, id);
    check("postclr_potential", potential, 32'h00000000);
    check("postclr_no_spike", spike_cycles, 0);
    check("postclr_done_once", dcnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
